mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 No parameters; operand and result width SHALL be fixed at 32 bits.
REQ-002 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-003 rst_n  in  1  reset, synchronous and active-low.
REQ-004 start  in  1  request a new operation; sampled only in IDLE.
REQ-005 op  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV.
REQ-006 a  in  32  operand A (register-file Rs read data); dividend for divides.
REQ-007 b  in  32  operand B (register-file Rt read data); divisor for divides.
REQ-008 hi_we  in  1  MTHI write strobe.
REQ-009 lo_we  in  1  MTLO write strobe.
REQ-010 wdata  in  32  MTHI/MTLO data.
REQ-011 busy  out  1  operation in progress.
REQ-012 done  out  1  one-cycle pulse: hi/lo hold the new result.
REQ-013 hi  out  32  HI register (product high word / remainder).
REQ-014 lo  out  32  LO register (product low word / quotient).

Function
REQ-015 FSM states SHALL be IDLE, CALC, FIX, DONE.
REQ-016 IDLE→CALC on an edge with start=1; a, b, op latched at that edge; busy=1 from the next cycle.
REQ-017 CALC SHALL run exactly 32 iterations via a 5-bit counter: one shift-add bit (multiply) or one restoring subtract-shift bit (divide) per cycle on operand magnitudes.
REQ-018 CALC→FIX after the 32nd iteration; FIX applies sign correction and writes hi/lo.
REQ-019 FIX→DONE; in DONE done=1, busy=0, hi/lo valid; DONE→IDLE next cycle, with start honoured there too.
REQ-020 Latency: done SHALL be high exactly 35 cycles after the start-sampling edge, identical for all ops and operands.
REQ-021 Multiply: {hi,lo} = full 64-bit product; MULT signed, MULTU unsigned.
REQ-022 Divide: lo = quotient truncated toward zero; hi = remainder with the dividend's sign.
REQ-023 Divide by zero (any divide op): lo = 32'hFFFFFFFF, hi = a; no error flag.
REQ-024 DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
REQ-025 start while busy=1 SHALL be ignored; no queuing.
REQ-026 hi_we/lo_we SHALL write hi/lo only when busy=0 and not in FIX; ignored otherwise.
REQ-027 hi_we/lo_we on the same edge as an accepted start: the write takes effect; the operation still starts and later overwrites both.
REQ-028 hi/lo SHALL be unchanged from start acceptance until the FIX edge.

Reset
REQ-029 rst_n=0 at an edge SHALL force IDLE, counter=0, busy=0, done=0, hi=0, lo=0, aborting any operation in progress with no result written.
REQ-030 start, hi_we, lo_we SHALL be ignored on any edge where rst_n=0.

Configuration
REQ-031 Macro MUL_DIV_SIGNED_EN: when defined, MULT/DIV are signed per REQ-021/022/024.
REQ-032 When MUL_DIV_SIGNED_EN is undefined, op[0] is ignored: MULT executes as MULTU, DIV as DIVU; sign-correction logic is absent; latency is unchanged.

Structure
REQ-033 Package mul_div_pkg SHALL hold the op encodings, the FSM state enum, and the 32-iteration count constant.
REQ-034 One sub-module, mul_div_step, SHALL implement the combinational single-iteration datapath (add/shift or subtract/shift); mul_div_unit holds the FSM, counter, and registers.

Verification
REQ-035 MULTU a=0xFFFFFFFF b=2 → after 35 cycles, done pulse; hi=0x00000001, lo=0xFFFFFFFE.
REQ-036 MULT a=0xFFFFFFFD(-3) b=5 → hi=0xFFFFFFFF, lo=0xFFFFFFF1 (signed build); unsigned build → hi=0x00000004, lo=0xFFFFFFF1.
REQ-037 DIV a=0xFFFFFFF9(-7) b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU a=100 b=0 → lo=0xFFFFFFFF, hi=0x00000064.
REQ-038 Second start at cycle 10 of a busy operation plus MTHI 0x1234 at cycle 12 → both ignored; first result intact, single done pulse.
REQ-039 rst_n low at cycle 20 of DIVU → next cycle busy=0, hi=lo=0, no done; new MULTU 3×4 → lo=12, hi=0.

Source files
------------

// File: rtl/mul_div_pkg.sv
// mul_div_pkg: shared definitions for the iterative multiply/divide unit.
//   - operation encodings (op_e) and small decode helpers
//   - FSM state encoding (state_e)
//   - data width and iteration count constants
package mul_div_pkg;

  localparam int XLEN       = 32;
  localparam int ITER_COUNT = 32;
  localparam int CNT_W      = 5;

  // Iteration counter is a down-counter: loaded with ITER_LAST, terminal count at zero.
  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER_COUNT - 1);

  typedef enum logic [1:0] {
    OP_MULTU = 2'b00,
    OP_MULT  = 2'b01,
    OP_DIVU  = 2'b10,
    OP_DIV   = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input logic [1:0] op);
    return (op_e'(op) == OP_DIVU) || (op_e'(op) == OP_DIV);
  endfunction

  function automatic logic op_is_signed(input logic [1:0] op);
    return (op_e'(op) == OP_MULT) || (op_e'(op) == OP_DIV);
  endfunction

endpackage

// File: rtl/mul_div_step.sv
// mul_div_step: one combinational iteration of the shared multiply/divide datapath.
// The 64-bit working value is split into upper (high word) and lower (low word).
//   multiply: upper = partial product high, lower = remaining multiplier bits;
//             conditional add of operand, then shift the 65-bit result right by one.
//   divide:   upper = partial remainder, lower = dividend bits / quotient bits;
//             shift left by one, restoring subtract of operand, quotient bit in LSB.
// Ports:
//   is_div_i   1     select divide step (1) or multiply step (0)
//   upper_i    32    current high word
//   lower_i    32    current low word
//   operand_i  32    multiplicand / divisor magnitude
//   upper_o    32    next high word
//   lower_o    32    next low word
module mul_div_step
  import mul_div_pkg::*;
(
  input  logic            is_div_i,
  input  logic [XLEN-1:0] upper_i,
  input  logic [XLEN-1:0] lower_i,
  input  logic [XLEN-1:0] operand_i,
  output logic [XLEN-1:0] upper_o,
  output logic [XLEN-1:0] lower_o
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   shifted;
  logic            fits;
  logic [XLEN-1:0] diff;

  always_comb begin
    sum     = {1'b0, upper_i} + (lower_i[0] ? {1'b0, operand_i} : '0);
    shifted = {upper_i, lower_i[XLEN-1]};
    fits    = (shifted >= {1'b0, operand_i});
    // When fits is set the true difference is below the divisor, so 32 bits suffice.
    diff    = shifted[XLEN-1:0] - operand_i;
    if (is_div_i) begin
      upper_o = fits ? diff : shifted[XLEN-1:0];
      lower_o = {lower_i[XLEN-2:0], fits};
    end else begin
      {upper_o, lower_o} = {sum, lower_i[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative 32x32 multiply / 32/32 divide unit with HI/LO registers.
// Fixed latency: done is high 35 cycles after the edge that accepts start,
// for every op and operand value.
// Build option: define MUL_DIV_SIGNED_EN to enable signed MULT/DIV. Without it,
// op[0] is ignored and every operation runs unsigned (same latency).
// Ports:
//   clk     1   clock, rising edge
//   rst_n   1   synchronous active-low reset
//   start   1   request operation (accepted in IDLE or DONE)
//   op      2   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a       32  operand A / dividend
//   b       32  operand B / divisor
//   hi_we   1   MTHI strobe (ignored while busy or in FIX)
//   lo_we   1   MTLO strobe (ignored while busy or in FIX)
//   wdata   32  MTHI/MTLO data
//   busy    1   operation in progress (CALC, FIX)
//   done    1   one-cycle pulse, hi/lo hold the new result
//   hi      32  HI register
//   lo      32  LO register
//
// state  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | waiting for start
// CALC   | phase 0: form operand magnitudes; phase 1: 32 step iterations
// FIX    | phase 0: sign correction of result; phase 1: write hi/lo
// DONE   | result valid, done pulse; start accepted here as well
module mul_div_unit
  import mul_div_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            hi_we,
  input  logic            lo_we,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             phase_q, phase_d;

  logic             is_div_q, is_div_d;
  logic [XLEN-1:0]  upper_q, upper_d;
  logic [XLEN-1:0]  lower_q, lower_d;
  logic [XLEN-1:0]  operand_q, operand_d;
  logic [XLEN-1:0]  hi_q, hi_d;
  logic [XLEN-1:0]  lo_q, lo_d;

  logic [XLEN-1:0]  step_upper;
  logic [XLEN-1:0]  step_lower;

  logic             accept;
  logic             prep;
  logic             iterating;
  logic             fix_prep;
  logic             fix_commit;

`ifdef MUL_DIV_SIGNED_EN
  logic             signed_q, signed_d;
  logic             neg_a_q, neg_a_d;
  logic             neg_b_q, neg_b_d;
  logic             b_nz_q, b_nz_d;
`else
  logic             unused_op_sign;
  assign unused_op_sign = op[0];
`endif

  assign accept     = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign prep       = (state_q == S_CALC) && !phase_q;
  assign iterating  = (state_q == S_CALC) && phase_q;
  assign fix_prep   = (state_q == S_FIX) && !phase_q;
  assign fix_commit = (state_q == S_FIX) && phase_q;

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    phase_d = phase_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = ITER_LAST;
          phase_d = 1'b0;
        end
      end
      S_CALC: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else if (cnt_q == '0) begin
          state_d = S_FIX;
          phase_d = 1'b0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_FIX: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          state_d = S_DONE;
          phase_d = 1'b0;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          cnt_d   = ITER_LAST;
          phase_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_CALC) || (state_q == S_FIX);
    done = (state_q == S_DONE);
  end

  // ----------------------------------------------------------- datapath
  mul_div_step u_step (
    .is_div_i  (is_div_q),
    .upper_i   (upper_q),
    .lower_i   (lower_q),
    .operand_i (operand_q),
    .upper_o   (step_upper),
    .lower_o   (step_lower)
  );

  always_comb begin
    upper_d   = upper_q;
    lower_d   = lower_q;
    operand_d = operand_q;
    is_div_d  = is_div_q;
`ifdef MUL_DIV_SIGNED_EN
    signed_d  = signed_q;
    neg_a_d   = neg_a_q;
    neg_b_d   = neg_b_q;
    b_nz_d    = b_nz_q;
`endif
    if (accept) begin
      upper_d   = '0;
      lower_d   = a;
      operand_d = b;
      is_div_d  = op_is_div(op);
`ifdef MUL_DIV_SIGNED_EN
      signed_d  = op_is_signed(op);
`endif
    end else if (prep) begin
`ifdef MUL_DIV_SIGNED_EN
      neg_a_d = signed_q & lower_q[XLEN-1];
      neg_b_d = signed_q & operand_q[XLEN-1];
      b_nz_d  = |operand_q;
      if (neg_a_d) lower_d = -lower_q;
      if (neg_b_d) operand_d = -operand_q;
`endif
    end else if (iterating) begin
      upper_d = step_upper;
      lower_d = step_lower;
    end else if (fix_prep) begin
`ifdef MUL_DIV_SIGNED_EN
      if (!is_div_q) begin
        if (neg_a_q ^ neg_b_q) {upper_d, lower_d} = -{upper_q, lower_q};
      end else begin
        // Divide by zero keeps the all-ones quotient; the remainder still
        // follows the dividend's sign, which restores the original a.
        if ((neg_a_q ^ neg_b_q) && b_nz_q) lower_d = -lower_q;
        if (neg_a_q) upper_d = -upper_q;
      end
`endif
    end
  end

  always_comb begin
    hi_d = hi_q;
    lo_d = lo_q;
    if (fix_commit) begin
      hi_d = upper_q;
      lo_d = lower_q;
    end else if (!busy) begin
      if (hi_we) hi_d = wdata;
      if (lo_we) lo_d = wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upper_q   <= '0;
      lower_q   <= '0;
      operand_q <= '0;
      is_div_q  <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MUL_DIV_SIGNED_EN
      signed_q  <= 1'b0;
      neg_a_q   <= 1'b0;
      neg_b_q   <= 1'b0;
      b_nz_q    <= 1'b0;
`endif
    end else begin
      upper_q   <= upper_d;
      lower_q   <= lower_d;
      operand_q <= operand_d;
      is_div_q  <= is_div_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MUL_DIV_SIGNED_EN
      signed_q  <= signed_d;
      neg_a_q   <= neg_a_d;
      neg_b_q   <= neg_b_d;
      b_nz_q    <= b_nz_d;
`endif
    end
  end

  assign hi = hi_q;
  assign lo = lo_q;

endmodule
